// File: rtl/permutation_sequencer.sv
// permutation_sequencer
// Control sequencer for the hypervector permutation unit. Accepts one n-gram
// command and emits one step per item (version index + inverse select) to the
// permutation datapath. Holds no vector data.
//
// Handshake rules (both interfaces):
//   - A transfer happens on a rising clock edge where valid and ready are both 1.
//   - Once step_valid_o is high it stays high, and every step_* output holds its
//     value, until the transfer completes. The one exception is abort_i: it
//     withdraws step_valid_o on the next edge, even in the middle of a stall.
//   - cmd_ready_o is high only in IDLE. It is combinationally forced low while
//     abort_i is high, so a command offered in an abort cycle is not accepted.
//   - No other output depends combinationally on any input.

module permutation_sequencer #(
  parameter int NUM_VERSIONS = 4,
  parameter int MAX_STEPS    = 16,
  parameter int VER_W        = (NUM_VERSIONS > 1) ? $clog2(NUM_VERSIONS) : 1,
  parameter int LEN_W        = $clog2(MAX_STEPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // command interface
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [VER_W-1:0] cmd_version_i,
  input  logic             cmd_inverse_i,
  input  logic             cmd_incr_i,
  input  logic             abort_i,
  // step interface
  output logic             step_valid_o,
  input  logic             step_ready_i,
  output logic [VER_W-1:0] step_version_o,
  output logic             step_inverse_o,
  output logic [LEN_W-1:0] step_idx_o,
  output logic             step_first_o,
  output logic             step_last_o,
  // completion
  output logic             done_o,
  output logic             error_o,
  // debug: current FSM state (0 IDLE, 1 RUN, 2 DONE)
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned NV_U  = NUM_VERSIONS;
  localparam int unsigned MAX_U = MAX_STEPS;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [VER_W-1:0] VER_ONE = VER_W'(1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             incr_q;

  logic             cmd_illegal;
  logic             handshake;
  logic [LEN_W-1:0] idx_next;
  logic             last_next;
  logic [VER_W-1:0] ver_wrap;

  // Command legality, next-step index/marker and wrapped version.
  always_comb begin
    cmd_illegal = (cmd_len_i == '0)
               || (32'(cmd_len_i) > MAX_U)
               || (32'(cmd_version_i) >= NV_U);
    handshake   = step_valid_o && step_ready_i;
    idx_next    = step_idx_o + LEN_ONE;
    last_next   = (idx_next == (len_q - LEN_ONE));
    ver_wrap    = (32'(step_version_o) == (NV_U - 1)) ? '0 : (step_version_o + VER_ONE);
  end

  // Command acceptance is the only input-to-output combinational path.
  assign cmd_ready_o = (state == S_IDLE) && !abort_i;
  assign dbg_state_o = state;

  // Sequencer FSM with registered step and completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      len_q          <= '0;
      incr_q         <= 1'b0;
      step_valid_o   <= 1'b0;
      step_version_o <= '0;
      step_inverse_o <= 1'b0;
      step_idx_o     <= '0;
      step_first_o   <= 1'b0;
      step_last_o    <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else if (abort_i) begin
      // Cancel whatever is in flight; no completion pulse.
      state          <= S_IDLE;
      step_valid_o   <= 1'b0;
      step_version_o <= '0;
      step_inverse_o <= 1'b0;
      step_idx_o     <= '0;
      step_first_o   <= 1'b0;
      step_last_o    <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o  <= 1'b0;
          error_o <= 1'b0;
          if (cmd_valid_i) begin
            len_q  <= cmd_len_i;
            incr_q <= cmd_incr_i;
            if (cmd_illegal) begin
              // Report straight away; the datapath never sees a step.
              state   <= S_DONE;
              done_o  <= 1'b1;
              error_o <= 1'b1;
            end else begin
              state          <= S_RUN;
              step_valid_o   <= 1'b1;
              step_version_o <= cmd_version_i;
              step_inverse_o <= cmd_inverse_i;
              step_idx_o     <= '0;
              step_first_o   <= 1'b1;
              step_last_o    <= (cmd_len_i == LEN_ONE);
            end
          end
        end

        S_RUN: begin
          if (handshake) begin
            if (step_last_o) begin
              state          <= S_DONE;
              done_o         <= 1'b1;
              error_o        <= 1'b0;
              step_valid_o   <= 1'b0;
              step_version_o <= '0;
              step_inverse_o <= 1'b0;
              step_idx_o     <= '0;
              step_first_o   <= 1'b0;
              step_last_o    <= 1'b0;
            end else begin
              step_idx_o   <= idx_next;
              step_first_o <= 1'b0;
              step_last_o  <= last_next;
              if (incr_q) begin
                step_version_o <= ver_wrap;
              end
            end
          end
        end

        S_DONE: begin
          // done_o/error_o were raised on entry; drop them after one cycle.
          state   <= S_IDLE;
          done_o  <= 1'b0;
          error_o <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A stalled step holds all of its fields until consumed or aborted.
  a_step_hold: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (step_valid_o && !step_ready_i && !abort_i)
      |=> (step_valid_o && $stable(step_version_o) && $stable(step_inverse_o)
           && $stable(step_idx_o) && $stable(step_first_o) && $stable(step_last_o))
  );

  // Commands are only offered as accepted from IDLE.
  a_ready_idle: assert property (
    @(posedge clk_i) disable iff (rst_i)
    cmd_ready_o |-> (state == S_IDLE)
  );

  // Completion never overlaps an outstanding step.
  a_done_no_step: assert property (
    @(posedge clk_i) disable iff (rst_i)
    done_o |-> !step_valid_o
  );

endmodule
